// File: rtl/hack_soc_pkg.sv
// Shared types for the Hack SoC memory path: arbiter state encoding, grant identity
// and the SRAM region select bit that separates instruction and data space.
package hack_soc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_ROM = 1'b0,
    GNT_RAM = 1'b1
  } grant_e;

  localparam logic SEL_ROM = 1'b0;
  localparam logic SEL_RAM = 1'b1;

  // Round-robin pick: on a tie the client that was not served last wins.
  function automatic grant_e rr_pick(input logic rom_req, input logic ram_req,
                                     input grant_e last_grant);
    grant_e pick;
    if (rom_req && ram_req) begin
      pick = (last_grant == GNT_RAM) ? GNT_ROM : GNT_RAM;
    end else if (rom_req) begin
      pick = GNT_ROM;
    end else begin
      pick = GNT_RAM;
    end
    return pick;
  endfunction

endpackage

// File: rtl/hack_mem_arbiter.sv
// Merges the Hack CPU fetch and data ports onto the single SPI SRAM encoder request
// interface; one transaction outstanding, request fields held stable until completion.
module hack_mem_arbiter
  import hack_soc_pkg::*;
#(
  parameter int WORD_WIDTH    = 16,
  parameter int CLIENT_AW     = 15,
  parameter int ADDRESS_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     rom_req,
  input  logic [CLIENT_AW-1:0]     rom_addr,
  output logic [WORD_WIDTH-1:0]    rom_rdata,
  output logic                     rom_valid,
  input  logic                     ram_req,
  input  logic                     ram_we,
  input  logic [CLIENT_AW-1:0]     ram_addr,
  input  logic [WORD_WIDTH-1:0]    ram_wdata,
  output logic [WORD_WIDTH-1:0]    ram_rdata,
  output logic                     ram_valid,
  output logic                     enc_request,
  output logic [ADDRESS_WIDTH-1:0] enc_address,
  output logic                     enc_write_enable,
  output logic [WORD_WIDTH-1:0]    enc_data_out,
  input  logic [WORD_WIDTH-1:0]    enc_data_in,
  input  logic                     enc_busy,
  input  logic                     enc_initialized
);

  arb_state_e               state_q, state_d;
  grant_e                   grant_q, grant_d;
  grant_e                   last_grant_q, last_grant_d;
  logic                     enc_request_q, enc_request_d;
  logic [ADDRESS_WIDTH-1:0] enc_address_q, enc_address_d;
  logic                     enc_we_q, enc_we_d;
  logic [WORD_WIDTH-1:0]    enc_wdata_q, enc_wdata_d;
  logic [WORD_WIDTH-1:0]    rom_rdata_q, rom_rdata_d;
  logic [WORD_WIDTH-1:0]    ram_rdata_q, ram_rdata_d;
  logic                     rom_valid_q, rom_valid_d;
  logic                     ram_valid_q, ram_valid_d;

  logic   start_grant;
  grant_e pick;

  assign start_grant = enc_initialized && !enc_busy && (rom_req || ram_req);
  assign pick        = rr_pick(rom_req, ram_req, last_grant_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= GNT_ROM;
      last_grant_q  <= GNT_RAM;
      enc_request_q <= 1'b0;
      enc_address_q <= '0;
      enc_we_q      <= 1'b0;
      enc_wdata_q   <= '0;
      rom_rdata_q   <= '0;
      ram_rdata_q   <= '0;
      rom_valid_q   <= 1'b0;
      ram_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      enc_request_q <= enc_request_d;
      enc_address_q <= enc_address_d;
      enc_we_q      <= enc_we_d;
      enc_wdata_q   <= enc_wdata_d;
      rom_rdata_q   <= rom_rdata_d;
      ram_rdata_q   <= ram_rdata_d;
      rom_valid_q   <= rom_valid_d;
      ram_valid_q   <= ram_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_grant) state_d = ST_ISSUE;
      ST_ISSUE: if (enc_busy)    state_d = ST_WAIT;
      ST_WAIT:  if (!enc_busy)   state_d = ST_DONE;
      ST_DONE:                   state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered: this block computes their next values. The valid pulse and
  // read data are loaded on the WAIT->DONE edge so valid is visible exactly in DONE.
  always_comb begin
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    enc_request_d = 1'b0;
    enc_address_d = enc_address_q;
    enc_we_d      = enc_we_q;
    enc_wdata_d   = enc_wdata_q;
    rom_rdata_d   = rom_rdata_q;
    ram_rdata_d   = ram_rdata_q;
    rom_valid_d   = 1'b0;
    ram_valid_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_grant) begin
          grant_d       = pick;
          last_grant_d  = pick;
          enc_request_d = 1'b1;
          if (pick == GNT_RAM) begin
            enc_address_d = {SEL_RAM, ram_addr};
            enc_we_d      = ram_we;
            enc_wdata_d   = ram_wdata;
          end else begin
            enc_address_d = {SEL_ROM, rom_addr};
            enc_we_d      = 1'b0;
            enc_wdata_d   = '0;
          end
        end
      end
      ST_ISSUE: enc_request_d = !enc_busy;
      ST_WAIT: begin
        if (!enc_busy) begin
          if (grant_q == GNT_RAM) begin
            ram_valid_d = 1'b1;
            if (!enc_we_q) ram_rdata_d = enc_data_in;
          end else begin
            rom_valid_d = 1'b1;
            rom_rdata_d = enc_data_in;
          end
        end
      end
      default: ;
    endcase
  end

  assign enc_request      = enc_request_q;
  assign enc_address      = enc_address_q;
  assign enc_write_enable = enc_we_q;
  assign enc_data_out     = enc_wdata_q;
  assign rom_rdata        = rom_rdata_q;
  assign ram_rdata        = ram_rdata_q;
  assign rom_valid        = rom_valid_q;
  assign ram_valid        = ram_valid_q;

endmodule

// File: tb/tb_hack_mem_arbiter.sv
// Self-checking bench for hack_mem_arbiter with a behavioural encoder/SRAM model and a
// request-level reference model of the arbitration and memory contents.
module tb_hack_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        rom_req;
  logic [14:0] rom_addr;
  logic [15:0] rom_rdata;
  logic        rom_valid;
  logic        ram_req;
  logic        ram_we;
  logic [14:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic        ram_valid;
  logic        enc_request;
  logic [15:0] enc_address;
  logic        enc_write_enable;
  logic [15:0] enc_data_out;
  logic [15:0] enc_data_in;
  logic        enc_busy;
  logic        enc_initialized;

  hack_mem_arbiter #(.WORD_WIDTH(16), .CLIENT_AW(15), .ADDRESS_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_rdata(rom_rdata), .rom_valid(rom_valid),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_valid(ram_valid),
    .enc_request(enc_request), .enc_address(enc_address), .enc_write_enable(enc_write_enable),
    .enc_data_out(enc_data_out), .enc_data_in(enc_data_in), .enc_busy(enc_busy),
    .enc_initialized(enc_initialized)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] data;
  } op_t;

  int n_cmp = 0;
  int n_fail = 0;
  int both_valid = 0;
  int valid_count = 0;
  int stab_err = 0;

  op_t         op_log[$];
  logic [15:0] sram[int];
  logic [15:0] ref_ram[int];
  int          last_served;
  logic [15:0] exp_ram_rdata;

  int          em_state;
  int          em_delay;
  int          em_len;
  logic        stall;
  logic [15:0] lat_addr;
  logic        lat_we;
  logic [15:0] lat_wdata;

  function automatic logic [15:0] preload(input int a);
    logic [15:0] v;
    v = 16'(a * 7 + 291);
    if (a >= 32768) v = v ^ 16'hA5A5;
    return v;
  endfunction

  function automatic logic [15:0] ram_expect(input logic [14:0] a);
    if (ref_ram.exists(int'(a))) return ref_ram[int'(a)];
    return preload(32768 + int'(a));
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic em_start();
    enc_busy  = 1'b1;
    lat_addr  = enc_address;
    lat_we    = enc_write_enable;
    lat_wdata = enc_data_out;
    em_len    = int'($urandom_range(0, 4));
    em_state  = 2;
  endtask

  // Encoder + SRAM model: accepts 1-3 cycles after a request, stays busy for a random
  // time and samples the request fields only at the end of the transfer.
  initial begin
    enc_busy    = 1'b0;
    enc_data_in = 16'h0;
    em_state    = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        enc_busy = 1'b0;
        em_state = 0;
      end else begin
        case (em_state)
          0: if (enc_request && enc_initialized) begin
               em_delay = int'($urandom_range(0, 2));
               if (em_delay == 0) em_start();
               else em_state = 1;
             end
          1: begin
               em_delay--;
               if (em_delay == 0) em_start();
             end
          default: begin
            if (enc_address !== lat_addr || enc_write_enable !== lat_we ||
                enc_data_out !== lat_wdata) stab_err++;
            if (!stall) begin
              if (em_len == 0) begin
                if (enc_write_enable) sram[int'(enc_address)] = enc_data_out;
                else enc_data_in = sram.exists(int'(enc_address)) ?
                                   sram[int'(enc_address)] : preload(int'(enc_address));
                op_log.push_back('{addr: enc_address, we: enc_write_enable, data: enc_data_out});
                enc_busy = 1'b0;
                em_state = 0;
              end else begin
                em_len--;
              end
            end
          end
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rom_valid && ram_valid) both_valid++;
      if (rom_valid || ram_valid) valid_count++;
    end
  end

  task automatic check_op(input string tag, input logic [15:0] exp_addr, input logic exp_we,
                          input logic [15:0] exp_data);
    op_t op;
    if (op_log.size() == 0) begin
      check_output({tag, "_op_present"}, 32'd0, 32'd1);
    end else begin
      op = op_log.pop_front();
      check_output({tag, "_enc_addr"}, op.addr, exp_addr);
      check_output({tag, "_enc_we"}, op.we, exp_we);
      if (exp_we) check_output({tag, "_enc_wdata"}, op.data, exp_data);
    end
  endtask

  // Raises the selected requests together and serves them to completion, predicting the
  // service order from the round-robin rule and the data from the reference memory.
  task automatic apply_stimulus(input bit do_rom, input logic [14:0] r_addr, input bit do_ram,
                                input bit we, input logic [14:0] d_addr, input logic [15:0] wd,
                                input bit scramble);
    bit pend_rom, pend_ram;
    int cyc, exp_who;
    logic [15:0] e;
    @(negedge clk);
    rom_req = do_rom; rom_addr = r_addr;
    ram_req = do_ram; ram_we = we; ram_addr = d_addr; ram_wdata = wd;
    pend_rom = do_rom; pend_ram = do_ram; cyc = 0;
    while ((pend_rom || pend_ram) && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (scramble && (enc_request || enc_busy)) begin
        ram_addr = 15'($urandom); ram_wdata = 16'($urandom);
      end
      if (rom_valid || ram_valid) begin
        if (pend_rom && pend_ram) exp_who = (last_served == 0) ? 1 : 0;
        else exp_who = pend_rom ? 0 : 1;
        check_output("grant_order", ram_valid ? 32'd1 : 32'd0, 32'(exp_who));
        last_served = ram_valid ? 1 : 0;
      end
      if (rom_valid && pend_rom) begin
        check_output("rom_rdata", rom_rdata, preload(int'(r_addr)));
        check_op("rom", {1'b0, r_addr}, 1'b0, 16'h0);
        rom_req = 1'b0; pend_rom = 0;
      end
      if (ram_valid && pend_ram) begin
        if (we) begin
          check_output("ram_rdata_hold", ram_rdata, exp_ram_rdata);
          check_op("ram_wr", {1'b1, d_addr}, 1'b1, wd);
          ref_ram[int'(d_addr)] = wd;
        end else begin
          e = ram_expect(d_addr);
          check_output("ram_rdata", ram_rdata, e);
          exp_ram_rdata = e;
          check_op("ram_rd", {1'b1, d_addr}, 1'b0, 16'h0);
        end
        ram_req = 1'b0; pend_ram = 0;
      end
    end
    if (pend_rom || pend_ram) begin
      check_output("txn_timeout", 32'd1, 32'd0);
      rom_req = 1'b0; ram_req = 1'b0;
    end
  endtask

  initial begin
    int cnt, vc, served;
    bit rr, rm;
    reset_n = 1'b0; enc_initialized = 1'b0; stall = 1'b0;
    rom_req = 1'b0; rom_addr = '0; ram_req = 1'b0; ram_we = 1'b0; ram_addr = '0; ram_wdata = '0;
    last_served = 1; exp_ram_rdata = 16'h0;
    #1;
    check_output("rst_enc_request", enc_request, 1'b0);
    check_output("rst_enc_address", enc_address, 16'h0);
    check_output("rst_valids", {rom_valid, ram_valid}, 2'b00);
    check_output("rst_rdata", {rom_rdata, ram_rdata}, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Fetch held before the encoder is initialised must not be issued.
    rom_req = 1'b1; rom_addr = 15'h0042; cnt = 0;
    repeat (6) begin @(negedge clk); if (enc_request || rom_valid) cnt++; end
    check_output("no_grant_uninit", 32'(cnt), 32'd0);
    enc_initialized = 1'b1;
    apply_stimulus(1'b1, 15'h0042, 1'b0, 1'b0, 15'h0, 16'h0, 1'b0);
    @(negedge clk);
    check_output("rom_valid_width", rom_valid, 1'b0);

    apply_stimulus(1'b0, 15'h0, 1'b1, 1'b1, 15'h1234, 16'hBEEF, 1'b0);
    apply_stimulus(1'b0, 15'h0, 1'b1, 1'b0, 15'h1234, 16'h0, 1'b0);
    check_output("ram_readback_beef", ram_rdata, 16'hBEEF);
    apply_stimulus(1'b1, 15'h1234, 1'b0, 1'b0, 15'h0, 16'h0, 1'b0);
    check_output("rom_no_alias", rom_rdata, preload(32'h1234));

    // Both requests held continuously: service must alternate.
    @(negedge clk);
    rom_req = 1'b1; rom_addr = 15'h0010; ram_req = 1'b1; ram_we = 1'b0; ram_addr = 15'h1234;
    served = 0; cnt = 0;
    while (served < 8 && cnt < 1000) begin
      @(negedge clk); cnt++;
      if (rom_valid || ram_valid) begin
        check_output("stream_alternate", ram_valid ? 32'd1 : 32'd0, last_served == 0 ? 32'd1 : 32'd0);
        last_served = ram_valid ? 1 : 0;
        if (rom_valid) begin
          check_output("stream_rom_rdata", rom_rdata, preload(32'h10));
          check_op("stream_rom", 16'h0010, 1'b0, 16'h0);
        end else begin
          check_output("stream_ram_rdata", ram_rdata, 16'hBEEF);
          check_op("stream_ram", 16'h9234, 1'b0, 16'h0);
        end
        served++;
        if (served == 8) begin rom_req = 1'b0; ram_req = 1'b0; end
      end
    end
    check_output("stream_count", 32'(served), 32'd8);
    rom_req = 1'b0; ram_req = 1'b0;

    apply_stimulus(1'b0, 15'h0, 1'b1, 1'b1, 15'h0100, 16'hCAFE, 1'b1);
    apply_stimulus(1'b0, 15'h0, 1'b1, 1'b0, 15'h0100, 16'h0, 1'b0);
    check_output("latched_wdata", ram_rdata, 16'hCAFE);

    for (int i = 0; i < 24; i++) begin
      rr = 1'($urandom); rm = 1'($urandom);
      if (!rr && !rm) rr = 1'b1;
      apply_stimulus(rr, 15'($urandom_range(0, 7)), rm, 1'($urandom),
                     15'($urandom_range(0, 7) + 15'h0200), 16'($urandom), 1'b0);
    end

    // Reset in the middle of a stalled write.
    @(negedge clk);
    ram_req = 1'b1; ram_we = 1'b1; ram_addr = 15'h0777; ram_wdata = 16'h1111; stall = 1'b1;
    cnt = 0;
    while (!enc_busy && cnt < 50) begin @(negedge clk); cnt++; end
    check_output("busy_seen", enc_busy, 1'b1);
    repeat (2) @(negedge clk);
    vc = valid_count;
    #2 reset_n = 1'b0;
    #1;
    check_output("midrst_enc_request", enc_request, 1'b0);
    check_output("midrst_enc_fields", {enc_address, enc_write_enable}, 17'h0);
    check_output("midrst_valid", {rom_valid, ram_valid}, 2'b00);
    ram_req = 1'b0; rom_req = 1'b1; rom_addr = 15'h0ABC; enc_initialized = 1'b0; stall = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1; last_served = 1; cnt = 0;
    repeat (4) begin @(negedge clk); if (enc_request) cnt++; end
    check_output("midrst_no_request", 32'(cnt), 32'd0);
    check_output("midrst_no_valid", 32'(valid_count), 32'(vc));
    enc_initialized = 1'b1;
    apply_stimulus(1'b1, 15'h0ABC, 1'b0, 1'b0, 15'h0, 16'h0, 1'b0);
    apply_stimulus(1'b0, 15'h0, 1'b1, 1'b0, 15'h0777, 16'h0, 1'b0);

    check_output("inv_valid_exclusive", 32'(both_valid), 32'd0);
    check_output("inv_fields_stable", 32'(stab_err), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
